// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by a word-addressed RAM (32-bit data, 1-bit IDs).
// One write burst and one read burst in flight at a time; the two channels run independently.
module axi4_slave_ram #(
    parameter int ADDR_LSB_WORDS = 10
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [0:0]  S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWLOCK,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWREGION,
    input  logic [3:0]  S_AXI_AWQOS,
    input  logic [0:0]  S_AXI_AWUSER,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [0:0]  S_AXI_WID,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic [0:0]  S_AXI_WUSER,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [0:0]  S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic [0:0]  S_AXI_BUSER,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [0:0]  S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARLOCK,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARREGION,
    input  logic [3:0]  S_AXI_ARQOS,
    input  logic [0:0]  S_AXI_ARUSER,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [0:0]  S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic [0:0]  S_AXI_RUSER,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int IW    = ADDR_LSB_WORDS;
    localparam int DEPTH = 1 << ADDR_LSB_WORDS;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == SIZE_WORD) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

    function automatic logic [IW-1:0] step_idx(input logic [IW-1:0] idx, input logic incr);
        return incr ? (idx + IDX_ONE) : idx;
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    // write channel state
    logic [1:0]    w_state_r;
    logic          awready_r;
    logic          wready_r;
    logic          bvalid_r;
    logic [0:0]    bid_r;
    logic [1:0]    bresp_r;
    logic [IW-1:0] w_idx_r;
    logic [7:0]    w_len_r;
    logic [7:0]    w_cnt_r;
    logic          w_legal_r;
    logic          w_incr_r;
    logic          w_err_r;

    // read channel state
    logic [0:0]    r_state_r;
    logic          arready_r;
    logic          rvalid_r;
    logic [0:0]    rid_r;
    logic [31:0]   rdata_r;
    logic [1:0]    rresp_r;
    logic          rlast_r;
    logic [IW-1:0] r_idx_r;
    logic [7:0]    r_len_r;
    logic [7:0]    r_cnt_r;
    logic          r_legal_r;
    logic          r_incr_r;

    logic          aw_fire_s;
    logic          w_fire_s;
    logic          b_fire_s;
    logic          ar_fire_s;
    logic          r_fire_s;
    logic [IW-1:0] aw_idx_s;
    logic [IW-1:0] ar_idx_s;
    logic          aw_legal_s;
    logic          ar_legal_s;
    logic          w_last_beat_s;
    logic          w_mismatch_s;
    logic          unused_s;

    assign aw_fire_s     = S_AXI_AWVALID & awready_r;
    assign w_fire_s      = S_AXI_WVALID & wready_r;
    assign b_fire_s      = bvalid_r & S_AXI_BREADY;
    assign ar_fire_s     = S_AXI_ARVALID & arready_r;
    assign r_fire_s      = rvalid_r & S_AXI_RREADY;
    assign aw_idx_s      = S_AXI_AWADDR[IW+1:2];
    assign ar_idx_s      = S_AXI_ARADDR[IW+1:2];
    assign aw_legal_s    = burst_legal(S_AXI_AWSIZE, S_AXI_AWBURST);
    assign ar_legal_s    = burst_legal(S_AXI_ARSIZE, S_AXI_ARBURST);
    assign w_last_beat_s = (w_cnt_r == w_len_r);
    // The beat count alone ends the burst; WLAST only feeds the error status.
    assign w_mismatch_s  = (S_AXI_WLAST != w_last_beat_s);

    assign unused_s = ^{S_AXI_AWADDR[31:IW+2], S_AXI_AWADDR[1:0], S_AXI_AWLOCK, S_AXI_AWCACHE,
                        S_AXI_AWPROT, S_AXI_AWREGION, S_AXI_AWQOS, S_AXI_AWUSER,
                        S_AXI_ARADDR[31:IW+2], S_AXI_ARADDR[1:0], S_AXI_ARLOCK, S_AXI_ARCACHE,
                        S_AXI_ARPROT, S_AXI_ARREGION, S_AXI_ARQOS, S_AXI_ARUSER,
                        S_AXI_WID, S_AXI_WUSER};

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BID     = bid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_BUSER   = 1'b0;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RID     = rid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RLAST   = rlast_r;
    assign S_AXI_RUSER   = 1'b0;

    // Write FSM: address capture, beat counting and response generation.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= 1'b0;
            bresp_r   <= RESP_OKAY;
            w_idx_r   <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_legal_r <= 1'b0;
            w_incr_r  <= 1'b0;
            w_err_r   <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_fire_s) begin
                        w_state_r <= W_DATA;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        bid_r     <= S_AXI_AWID;
                        w_idx_r   <= aw_idx_s;
                        w_len_r   <= S_AXI_AWLEN;
                        w_cnt_r   <= 8'd0;
                        w_legal_r <= aw_legal_s;
                        w_incr_r  <= (S_AXI_AWBURST == BURST_INCR);
                        w_err_r   <= ~aw_legal_s;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        w_idx_r <= step_idx(w_idx_r, w_incr_r);
                        w_cnt_r <= w_cnt_r + 8'd1;
                        if (w_last_beat_s) begin
                            w_state_r <= W_RESP;
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= (w_err_r | w_mismatch_s) ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            w_err_r <= w_err_r | w_mismatch_s;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire_s) begin
                        w_state_r <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane RAM write; contents intentionally have no reset.
    always_ff @(posedge ACLK) begin
        if (w_fire_s && w_legal_r) begin
            for (int i = 0; i < 4; i++) begin
                if (S_AXI_WSTRB[i]) begin
                    mem[w_idx_r][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
                end
            end
        end
    end

    // Read FSM: r_idx_r always points at the word for the next beat to load.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rid_r     <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
            rlast_r   <= 1'b0;
            r_idx_r   <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_legal_r <= 1'b0;
            r_incr_r  <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_fire_s) begin
                        r_state_r <= R_DATA;
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rid_r     <= S_AXI_ARID;
                        r_len_r   <= S_AXI_ARLEN;
                        r_cnt_r   <= 8'd0;
                        r_legal_r <= ar_legal_s;
                        r_incr_r  <= (S_AXI_ARBURST == BURST_INCR);
                        r_idx_r   <= step_idx(ar_idx_s, S_AXI_ARBURST == BURST_INCR);
                        rdata_r   <= ar_legal_s ? mem[ar_idx_s] : 32'h0000_0000;
                        rresp_r   <= ar_legal_s ? RESP_OKAY : RESP_SLVERR;
                        rlast_r   <= (S_AXI_ARLEN == 8'd0);
                    end
                end
                R_DATA: begin
                    if (r_fire_s) begin
                        if (rlast_r) begin
                            r_state_r <= R_IDLE;
                            rvalid_r  <= 1'b0;
                            arready_r <= 1'b1;
                        end else begin
                            r_cnt_r <= r_cnt_r + 8'd1;
                            r_idx_r <= step_idx(r_idx_r, r_incr_r);
                            rdata_r <= r_legal_r ? mem[r_idx_r] : 32'h0000_0000;
                            rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Randomized bench for axi4_slave_ram: a word-array model predicts every B and R beat,
// and a negedge monitor compares each valid response cycle against it.
module tb_axi4_slave_ram;

    localparam int IW    = 10;
    localparam int DEPTH = 1 << IW;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  S_AXI_AWID, S_AXI_AWUSER, S_AXI_WID, S_AXI_WUSER, S_AXI_ARID, S_AXI_ARUSER;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWPROT, S_AXI_ARPROT;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST;
    logic        S_AXI_AWLOCK, S_AXI_ARLOCK;
    logic [3:0]  S_AXI_AWCACHE, S_AXI_AWREGION, S_AXI_AWQOS;
    logic [3:0]  S_AXI_ARCACHE, S_AXI_ARREGION, S_AXI_ARQOS;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic [3:0]  S_AXI_WSTRB;
    logic [0:0]  S_AXI_BID, S_AXI_BUSER, S_AXI_RID, S_AXI_RUSER;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axi4_slave_ram #(.ADDR_LSB_WORDS(IW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
        .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWREGION(S_AXI_AWREGION),
        .S_AXI_AWQOS(S_AXI_AWQOS), .S_AXI_AWUSER(S_AXI_AWUSER), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WID(S_AXI_WID), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WUSER(S_AXI_WUSER), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BUSER(S_AXI_BUSER),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
        .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREGION(S_AXI_ARREGION),
        .S_AXI_ARQOS(S_AXI_ARQOS), .S_AXI_ARUSER(S_AXI_ARUSER), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic       id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    logic [31:0] model_mem [0:DEPTH-1];
    logic [31:0] wdat [0:255];
    logic [3:0]  wstb [0:255];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;
    logic [1:0]  last_bresp;
    logic        last_rlast;
    logic        last_bid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s actual=%s expected=none", name, what);
    endtask

    function automatic bit legal_burst(input logic [2:0] size, input logic [1:0] burst);
        return (size == 3'b010) && (burst == 2'b00 || burst == 2'b01);
    endfunction

    function automatic int word_of(input logic [31:0] addr, input logic [1:0] burst, input int k);
        return (int'(addr[IW+1:2]) + ((burst == 2'b01) ? k : 0)) % DEPTH;
    endfunction

    // Response monitor: every cycle a VALID is high, the payload must match the queue head.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (S_AXI_RVALID) begin
                if (rq.size() == 0) begin
                    flag("r_spurious", "rvalid");
                end else begin
                    chk("rid",   32'(S_AXI_RID),   32'(rq[0].id));
                    chk("rdata", S_AXI_RDATA,      rq[0].data);
                    chk("rresp", 32'(S_AXI_RRESP), 32'(rq[0].resp));
                    chk("rlast", 32'(S_AXI_RLAST), 32'(rq[0].last));
                    if (S_AXI_RREADY) begin
                        last_rdata = S_AXI_RDATA;
                        last_rresp = S_AXI_RRESP;
                        last_rlast = S_AXI_RLAST;
                        void'(rq.pop_front());
                    end
                end
            end
            if (S_AXI_BVALID) begin
                if (bq.size() == 0) begin
                    flag("b_spurious", "bvalid");
                end else begin
                    chk("bid",   32'(S_AXI_BID),   32'(bq[0].id));
                    chk("bresp", 32'(S_AXI_BRESP), 32'(bq[0].resp));
                    if (S_AXI_BREADY) begin
                        last_bresp = S_AXI_BRESP;
                        last_bid   = S_AXI_BID;
                        void'(bq.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit hs);
        int   t;
        logic wr_at_hs;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        hs = 1'b0; t = 0; wr_at_hs = 1'b0;
        while (!hs && t < 100) begin
            @(negedge ACLK);
            hs = S_AXI_AWREADY;
            wr_at_hs = S_AXI_WREADY;
            @(posedge ACLK);
            t++;
        end
        #1;
        S_AXI_AWVALID = 1'b0;
        if (!hs) flag("aw_timeout", "no_awready");
        else chk("wready_before_aw", 32'(wr_at_hs), 32'd0);
    endtask

    task automatic send_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit hs);
        int t;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        hs = 1'b0; t = 0;
        while (!hs && t < 100) begin
            @(negedge ACLK);
            hs = S_AXI_ARREADY;
            @(posedge ACLK);
            t++;
        end
        #1;
        S_AXI_ARVALID = 1'b0;
        if (!hs) flag("ar_timeout", "no_arready");
    endtask

    // Write of wdat/wstb[0..len]; early >= 0 puts WLAST on that beat instead of the last one.
    task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int early);
        bit    hs, legal, err, lastk;
        int    t, idx;
        bexp_t b;
        legal = legal_burst(size, burst);
        err = !legal;
        for (int k = 0; k <= int'(len); k++) begin
            lastk = (early >= 0) ? (k == early) : (k == int'(len));
            if (lastk != (k == int'(len))) err = 1'b1;
        end
        b.id = id;
        b.resp = err ? 2'b10 : 2'b00;
        bq.push_back(b);
        send_aw(id, addr, len, size, burst, hs);
        if (!hs) begin
            bq.delete();
            return;
        end
        for (int k = 0; k <= int'(len); k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge ACLK); #1;
            end
            S_AXI_WVALID = 1'b1;
            S_AXI_WDATA  = wdat[k];
            S_AXI_WSTRB  = wstb[k];
            S_AXI_WLAST  = (early >= 0) ? (k == early) : (k == int'(len));
            hs = 1'b0; t = 0;
            while (!hs && t < 100) begin
                @(negedge ACLK);
                hs = S_AXI_WREADY;
                @(posedge ACLK);
                t++;
            end
            #1;
            S_AXI_WVALID = 1'b0;
            S_AXI_WLAST  = 1'b0;
            if (!hs) begin
                flag("w_timeout", "no_wready");
                break;
            end
            if (legal) begin
                idx = word_of(addr, burst, k);
                for (int bl = 0; bl < 4; bl++)
                    if (wstb[k][bl]) model_mem[idx][8*bl +: 8] = wdat[k][8*bl +: 8];
            end
        end
        t = 0;
        while (bq.size() != 0 && t < 100) begin
            S_AXI_BREADY = 1'($urandom_range(0, 1));
            @(posedge ACLK); #1;
            t++;
        end
        S_AXI_BREADY = 1'b0;
        if (bq.size() != 0) begin
            flag("b_timeout", "no_bvalid");
            bq.delete();
        end
    endtask

    task automatic exp_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        rbeat_t e;
        bit     legal;
        legal = legal_burst(size, burst);
        for (int k = 0; k <= int'(len); k++) begin
            e.id   = id;
            e.data = legal ? model_mem[word_of(addr, burst, k)] : 32'h0;
            e.resp = legal ? 2'b00 : 2'b10;
            e.last = (k == int'(len));
            rq.push_back(e);
        end
    endtask

    // hold=1 keeps RREADY high and requires a gap-free burst.
    task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit hold);
        bit hs;
        int t, bubbles;
        exp_read(id, addr, len, size, burst);
        S_AXI_RREADY = hold ? 1'b1 : 1'($urandom_range(0, 1));
        send_ar(id, addr, len, size, burst, hs);
        if (!hs) begin
            rq.delete();
            return;
        end
        chk("r_first_beat_latency", 32'(S_AXI_RVALID), 32'd1);
        bubbles = 0; t = 0;
        while (rq.size() != 0 && t < 1000) begin
            if (!hold) S_AXI_RREADY = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            if (!S_AXI_RVALID) bubbles++;
            @(posedge ACLK); #1;
            t++;
        end
        S_AXI_RREADY = 1'b0;
        if (rq.size() != 0) begin
            flag("r_timeout", "beats_missing");
            rq.delete();
        end
        if (hold) chk("r_bubbles", 32'(bubbles), 32'd0);
    endtask

    initial begin
        bit          hs;
        logic        rid;
        logic [31:0] ra;
        logic [7:0]  rlen;
        logic [2:0]  rsz;
        logic [1:0]  rbu;
        int          early;

        ARESETN = 1'b0;
        {S_AXI_AWID, S_AXI_AWUSER, S_AXI_WID, S_AXI_WUSER, S_AXI_ARID, S_AXI_ARUSER} = '0;
        {S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_AWLEN, S_AXI_ARLEN} = '0;
        {S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWBURST, S_AXI_ARBURST} = '0;
        {S_AXI_AWLOCK, S_AXI_ARLOCK, S_AXI_AWCACHE, S_AXI_AWREGION, S_AXI_AWQOS} = '0;
        {S_AXI_ARCACHE, S_AXI_ARREGION, S_AXI_ARQOS} = '0;
        {S_AXI_AWVALID, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WSTRB} = '0;
        {S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY} = '0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        chk("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        chk("rst_bresp_bid", 32'({S_AXI_BID, S_AXI_BRESP}), 32'd0);
        chk("rst_rdata",   S_AXI_RDATA, 32'd0);
        chk("rst_rlast_rresp_rid", 32'({S_AXI_RLAST, S_AXI_RRESP, S_AXI_RID}), 32'd0);
        chk("user_tied",   32'({S_AXI_BUSER, S_AXI_RUSER}), 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // Preload the whole RAM so every later read has a known expectation.
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 256; k++) begin
                wdat[k] = $urandom;
                wstb[k] = 4'hF;
            end
            do_write(1'b0, 32'(p * 1024), 8'd255, 3'b010, 2'b01, -1);
        end

        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(1'b1, 32'h10, 8'd0, 3'b010, 2'b01, -1);
        chk("single_bresp", 32'(last_bresp), 32'd0);
        chk("single_bid", 32'(last_bid), 32'd1);
        do_read(1'b1, 32'h10, 8'd0, 3'b010, 2'b01, 1'b1);
        chk("single_rdata", last_rdata, 32'hDEADBEEF);
        chk("single_rlast_rresp", 32'({last_rlast, last_rresp}), 32'h4);

        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'(k + 1); wstb[k] = 4'hF;
        end
        do_write(1'b0, 32'h100, 8'd3, 3'b010, 2'b01, -1);
        do_read(1'b0, 32'h100, 8'd3, 3'b010, 2'b01, 1'b1);
        chk("incr_last_rdata", last_rdata, 32'd4);

        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        do_write(1'b0, 32'h200, 8'd0, 3'b010, 2'b01, -1);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
        do_write(1'b1, 32'h200, 8'd0, 3'b010, 2'b01, -1);
        do_read(1'b0, 32'h200, 8'd0, 3'b010, 2'b01, 1'b0);
        chk("strobe_merge", last_rdata, 32'h11BB33DD);

        for (int k = 0; k < 3; k++) begin
            wdat[k] = 32'(k + 5); wstb[k] = 4'hF;
        end
        do_write(1'b0, 32'h20, 8'd2, 3'b010, 2'b00, -1);
        do_read(1'b0, 32'h20, 8'd0, 3'b010, 2'b01, 1'b1);
        chk("fixed_final", last_rdata, 32'd7);

        wdat[0] = 32'h99999999; wdat[1] = 32'h88888888; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(1'b1, 32'h30, 8'd1, 3'b010, 2'b10, -1);
        chk("wrap_write_slverr", 32'(last_bresp), 32'd2);
        do_write(1'b0, 32'h34, 8'd0, 3'b001, 2'b01, -1);
        chk("size1_write_slverr", 32'(last_bresp), 32'd2);
        do_read(1'b0, 32'h30, 8'd1, 3'b010, 2'b01, 1'b0);
        do_read(1'b1, 32'h30, 8'd1, 3'b010, 2'b10, 1'b1);
        chk("wrap_read_rresp", 32'(last_rresp), 32'd2);
        chk("wrap_read_rdata", last_rdata, 32'd0);

        for (int k = 0; k < 3; k++) begin
            wdat[k] = $urandom; wstb[k] = 4'hF;
        end
        do_write(1'b0, 32'h50, 8'd2, 3'b010, 2'b01, 1);
        chk("early_wlast_slverr", 32'(last_bresp), 32'd2);
        do_read(1'b0, 32'h50, 8'd2, 3'b010, 2'b01, 1'b0);

        // Reset during a stalled read burst.
        S_AXI_RREADY = 1'b0;
        exp_read(1'b1, 32'h40, 8'd7, 3'b010, 2'b01);
        send_ar(1'b1, 32'h40, 8'd7, 3'b010, 2'b01, hs);
        repeat (3) begin
            @(posedge ACLK); #1;
        end
        ARESETN = 1'b0;
        #1;
        chk("midrst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        chk("midrst_arready", 32'(S_AXI_ARREADY), 32'd1);
        chk("midrst_awready", 32'(S_AXI_AWREADY), 32'd1);
        chk("midrst_bvalid_wready", 32'({S_AXI_BVALID, S_AXI_WREADY}), 32'd0);
        rq.delete();
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        do_read(1'b0, 32'h40, 8'd3, 3'b010, 2'b01, 1'b1);

        wdat[0] = 32'hA1; wdat[1] = 32'hB2; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(1'b1, 32'hFFC, 8'd1, 3'b010, 2'b01, -1);
        do_read(1'b0, 32'h0, 8'd0, 3'b010, 2'b01, 1'b1);
        chk("top_wrap_word0", last_rdata, 32'hB2);
        do_read(1'b1, 32'h1FFC, 8'd1, 3'b010, 2'b01, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rid  = 1'($urandom);
            ra   = $urandom;
            rlen = 8'($urandom_range(0, 15));
            rsz  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
            rbu  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            early = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rlen))) : -1;
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= int'(rlen); k++) begin
                    wdat[k] = $urandom;
                    wstb[k] = 4'($urandom);
                end
                do_write(rid, ra, rlen, rsz, rbu, early);
            end else begin
                do_read(rid, ra, rlen, rsz, rbu, 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_slave_ram.md
# axi4_slave_ram

AXI4 slave with an internal word-addressed RAM, 32-bit data and 1-bit IDs. It is the downstream target of the AXI4 master bus functional model: it consumes the S_AXI_* write and read traffic the master produces and returns responses. It handles one write burst and one read burst at a time, with the write and read channels independent. It is synthesizable and also serves as the reference slave in BFM regression benches.

## Interface
- ADDR_LSB_WORDS, default 10: log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- ACLK  in  1  clock; all state changes on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWID / AWADDR / AWLEN / AWSIZE / AWBURST  in  1/32/8/3/2  write address fields.
- S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1.
- S_AXI_WDATA / WSTRB / WLAST  in  32/4/1  write data beat.
- S_AXI_WVALID  in  1;  S_AXI_WREADY  out  1.
- S_AXI_BID / BRESP  out  1/2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1.
- S_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST  in  1/32/8/3/2  read address fields.
- S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1.
- S_AXI_RID / RDATA / RRESP / RLAST  out  1/32/2/1;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1.
- S_AXI_AW/ARLOCK, CACHE, PROT, REGION, QOS, USER; S_AXI_WID, WUSER  in  per AXI4  accepted and ignored.
- S_AXI_BUSER, S_AXI_RUSER  out  1  tied 0.

## Operation
- Word index is ADDR[ADDR_LSB_WORDS+1:2]. Upper address bits and ADDR[1:0] are ignored. The index wraps modulo depth.
- Legal burst: SIZE = 3'b010 and BURST = FIXED (00) or INCR (01). INCR advances the index by 1 per beat. FIXED holds the index.
- Illegal burst (WRAP, reserved, or SIZE ≠ 2):
  - Writes: beats are still accepted, the RAM is not written, and the response is SLVERR (2'b10).
  - Reads: beats return RDATA = 0 with RRESP = SLVERR.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY = 1 and WREADY = 0. On the AW handshake, latch ID, index, LEN and legality, clear the beat counter, and go to W_DATA.
  - W_DATA: WREADY = 1. On each W handshake, write bytes with WSTRB[i] = 1 (if legal), then advance the index and counter.
  - The burst ends on beat LEN+1; WLAST is not used to terminate.
  - If WLAST disagrees with (counter == LEN) on any beat, the response is SLVERR.
  - After the final beat, go to W_RESP.
  - W_RESP: BVALID = 1, BID = latched ID, BRESP held until BREADY. Then go to W_IDLE.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY = 1. On the AR handshake, register RDATA ← RAM[index], RLAST = (LEN == 0), RVALID = 1, and go to R_DATA.
  - R_DATA: ARREADY = 0. RID, RDATA, RRESP and RLAST are held stable while RVALID && !RREADY.
  - On each R handshake that is not the last beat, load the next beat in the same edge, so there are no bubbles.
  - On the handshake with RLAST = 1: RVALID ← 0 and go to R_IDLE.
- A write and a read on the same edge and same word: the read returns the pre-write data.
- RAM contents are not reset.

## Timing
- Reset value of every output is 0, except AWREADY = 1 and ARREADY = 1 (idle).
- Reset mid-burst returns both FSMs to IDLE immediately, drops VALIDs, and sends no response for the aborted burst. Any RAM beats already written remain.
- AW handshake at edge N: WREADY = 1 after N. Data beats presented with AW are accepted no earlier than edge N+1.
- Last W handshake at edge M: BVALID = 1 after M. The next AW is accepted no earlier than the edge following the B handshake.
- AR handshake at edge N: first beat valid after N (1-cycle latency). With RREADY held high, throughput is 1 beat per cycle and RLAST follows edge N+LEN.
- BVALID and RVALID never depend combinationally on READY inputs. VALIDs, once asserted, stay asserted until their handshake.

## Test plan
- Single write then read: AW 0x10, W 0xDEADBEEF with STRB 1111, LEN 0 → BRESP 00, BID = AWID. The following read of 0x10 returns 0xDEADBEEF with RLAST = 1 and RRESP 00, one cycle after ARREADY.
- INCR write LEN 3 at 0x100, data 1..4, RREADY high, then read LEN 3 → RDATA 1,2,3,4 on consecutive cycles, RLAST only on beat 4.
- Strobes: preload 0x11223344, write 0xAABBCCDD with STRB 0101 → readback 0x11BB33DD.
- FIXED write LEN 2 at 0x20, data 5,6,7 → reading 0x20 returns 7. Also: a WRAP burst and a SIZE = 1 burst each return SLVERR with RAM unchanged.
- Early WLAST on beat 1 of a LEN 2 write → all 3 beats are accepted and BRESP = SLVERR. Separately: random RREADY/BREADY stalls keep RDATA/BRESP stable until the handshake.
- Assert ARESETN low mid read burst → RVALID = 0, ARREADY = 1, and a new read after release completes correctly. Separately: an INCR write at the top word wraps to word 0.
